// File: rtl/cardinal_router_mesh_xy_nvc.sv
// 5-port XY mesh router with NUM_VC time-multiplexed VCs; the VC in phase owns the external links.
// Minimum latency NUM_VC cycles; ri drops when FIFO[p][phase] is full, a flit refused by ro waits one VC rotation.
module cardinal_router_mesh_xy_nvc #(
   parameter int  DATA_W     = 64,
   parameter int  NUM_VC     = 2,
   parameter int  FIFO_DEPTH = 2,
   localparam int PH_W       = $clog2(NUM_VC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              n_si,
   input  logic [DATA_W-1:0] n_di,
   output logic              n_ri,
   output logic              n_so,
   output logic [DATA_W-1:0] n_do,
   input  logic              n_ro,
   input  logic              s_si,
   input  logic [DATA_W-1:0] s_di,
   output logic              s_ri,
   output logic              s_so,
   output logic [DATA_W-1:0] s_do,
   input  logic              s_ro,
   input  logic              e_si,
   input  logic [DATA_W-1:0] e_di,
   output logic              e_ri,
   output logic              e_so,
   output logic [DATA_W-1:0] e_do,
   input  logic              e_ro,
   input  logic              w_si,
   input  logic [DATA_W-1:0] w_di,
   output logic              w_ri,
   output logic              w_so,
   output logic [DATA_W-1:0] w_do,
   input  logic              w_ro,
   input  logic              pe_si,
   input  logic [DATA_W-1:0] pe_di,
   output logic              pe_ri,
   output logic              pe_so,
   output logic [DATA_W-1:0] pe_do,
   input  logic              pe_ro,
   output logic [PH_W-1:0]   phase
);
   localparam int NP   = 5;
   localparam int P_N  = 0;
   localparam int P_S  = 1;
   localparam int P_E  = 2;
   localparam int P_W  = 3;
   localparam int P_PE = 4;

   logic [NP-1:0]     si, ri, so, ro, req, pop;
   logic [DATA_W-1:0] di   [NP];
   logic [DATA_W-1:0] dout [NP];
   logic [DATA_W-1:0] fwd  [NP];
   logic [2:0]        dst  [NP];
   logic [PH_W-1:0]   phase_q, phase_d, int_vc;
   logic              full_w  [NP][NUM_VC];
   logic              empty_w [NP][NUM_VC];
   logic [DATA_W-1:0] head_w  [NP][NUM_VC];
   logic [NUM_VC-1:0] ov_q [NP];
   logic [NUM_VC-1:0] ov_d [NP];
   logic [DATA_W-1:0] od_q [NP][NUM_VC];
   logic [DATA_W-1:0] od_d [NP][NUM_VC];
   logic [2:0]        rr_q [NP];
   logic [2:0]        rr_d [NP];

   assign si = {pe_si, w_si, e_si, s_si, n_si};
   assign ro = {pe_ro, w_ro, e_ro, s_ro, n_ro};
   assign di[P_N]  = n_di;
   assign di[P_S]  = s_di;
   assign di[P_E]  = e_di;
   assign di[P_W]  = w_di;
   assign di[P_PE] = pe_di;
   assign {pe_ri, w_ri, e_ri, s_ri, n_ri} = ri;
   assign {pe_so, w_so, e_so, s_so, n_so} = so;
   assign n_do  = dout[P_N];
   assign s_do  = dout[P_S];
   assign e_do  = dout[P_E];
   assign w_do  = dout[P_W];
   assign pe_do = dout[P_PE];
   assign phase = phase_q;

   // The switch always works on the VC that owns the links next cycle.
   always_comb begin
      phase_d = (phase_q == PH_W'(NUM_VC - 1)) ? '0 : phase_q + PH_W'(1);
      int_vc  = phase_d;
   end

   for (genvar p = 0; p < NP; p++) begin : g_port
      for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
         cardinal_router_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push_vld (si[p] && (phase_q == PH_W'(v))),
            .push_dat (di[p]),
            .pop_rdy  (pop[p] && (int_vc == PH_W'(v))),
            .full     (full_w[p][v]),
            .empty    (empty_w[p][v]),
            .head_dat (head_w[p][v])
         );
      end
   end

   always_comb begin
      for (int p = 0; p < NP; p++) begin
         ri[p]   = !full_w[p][phase_q];
         so[p]   = ov_q[p][phase_q];
         dout[p] = od_q[p][phase_q];
         req[p]  = !empty_w[p][int_vc];
         fwd[p]  = head_w[p][int_vc];
         dst[p]  = 3'(P_PE);
         if (fwd[p][55:52] != 4'd0) begin
            dst[p]        = fwd[p][56] ? 3'(P_E) : 3'(P_W);
            fwd[p][55:52] = fwd[p][55:52] - 4'd1;
         end else if (fwd[p][51:48] != 4'd0) begin
            dst[p]        = fwd[p][57] ? 3'(P_N) : 3'(P_S);
            fwd[p][51:48] = fwd[p][51:48] - 4'd1;
         end
      end
   end

   // Drain on ext VC and switch on int VC touch disjoint outreg entries.
   always_comb begin
      int   idx;
      int   gnt;
      logic gnt_vld;
      idx     = 0;
      gnt     = 0;
      gnt_vld = 1'b0;
      ov_d    = ov_q;
      od_d    = od_q;
      rr_d    = rr_q;
      pop     = '0;
      for (int p = 0; p < NP; p++) begin
         if (so[p] && ro[p]) ov_d[p][phase_q] = 1'b0;
      end
      for (int o = 0; o < NP; o++) begin
         gnt_vld = 1'b0;
         gnt     = 0;
         for (int k = 0; k < NP; k++) begin
            idx = int'(rr_q[o]) + k;
            if (idx >= NP) idx = idx - NP;
            if (!gnt_vld && !ov_q[o][int_vc] && req[idx] && (dst[idx] == 3'(o))) begin
               gnt_vld = 1'b1;
               gnt     = idx;
            end
         end
         if (gnt_vld) begin
            pop[gnt]        = 1'b1;
            ov_d[o][int_vc] = 1'b1;
            od_d[o][int_vc] = fwd[gnt];
            rr_d[o]         = (gnt == NP - 1) ? 3'd0 : 3'(gnt + 1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q <= '0;
         for (int p = 0; p < NP; p++) begin
            ov_q[p] <= '0;
            rr_q[p] <= '0;
            for (int v = 0; v < NUM_VC; v++) od_q[p][v] <= '0;
         end
      end else begin
         phase_q <= phase_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         rr_q    <= rr_d;
      end
   end
endmodule

// Circular FIFO, any depth >= 1; head visible combinationally, full pushes and empty pops are ignored.
module cardinal_router_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   input  logic         pop_rdy,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head_dat
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full     = (cnt_q == CW'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign head_dat = mem_q[rp_q];

   always_comb begin
      mem_d   = mem_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      do_push = push_vld && !full;
      do_pop  = pop_rdy && !empty;
      if (do_push) begin
         mem_d[wp_q] = push_dat;
         wp_d        = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
      end
      if (do_pop) rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_cardinal_router_mesh_xy_nvc.sv
// Directed scoreboard bench: instance A (2 VCs, depth 2) and instance B (3 VCs, depth 3) share clock and reset.
module tb_cardinal_router_mesh_xy_nvc;
   localparam int P_N  = 0;
   localparam int P_S  = 1;
   localparam int P_E  = 2;
   localparam int P_W  = 3;
   localparam int P_PE = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        si_w [2][5];
   logic [63:0] di_w [2][5];
   logic        ri_w [2][5];
   logic        so_w [2][5];
   logic [63:0] do_w [2][5];
   logic        ro_w [2][5];
   logic [0:0]  a_phase;
   logic [1:0]  b_phase;
   logic        b_hold = 1'b0;

   typedef struct {
      logic [63:0] dat;
      int          vc;
      int          cyc;
   } exp_t;
   exp_t exq [10][$];
   int   n_cmp = 0;
   int   n_bad = 0;

   cardinal_router_mesh_xy_nvc #(.DATA_W(64), .NUM_VC(2), .FIFO_DEPTH(2)) u_dut_a (
      .clk(clk), .reset(rst),
      .n_si(si_w[0][0]), .n_di(di_w[0][0]), .n_ri(ri_w[0][0]), .n_so(so_w[0][0]), .n_do(do_w[0][0]), .n_ro(ro_w[0][0]),
      .s_si(si_w[0][1]), .s_di(di_w[0][1]), .s_ri(ri_w[0][1]), .s_so(so_w[0][1]), .s_do(do_w[0][1]), .s_ro(ro_w[0][1]),
      .e_si(si_w[0][2]), .e_di(di_w[0][2]), .e_ri(ri_w[0][2]), .e_so(so_w[0][2]), .e_do(do_w[0][2]), .e_ro(ro_w[0][2]),
      .w_si(si_w[0][3]), .w_di(di_w[0][3]), .w_ri(ri_w[0][3]), .w_so(so_w[0][3]), .w_do(do_w[0][3]), .w_ro(ro_w[0][3]),
      .pe_si(si_w[0][4]), .pe_di(di_w[0][4]), .pe_ri(ri_w[0][4]), .pe_so(so_w[0][4]), .pe_do(do_w[0][4]), .pe_ro(ro_w[0][4]),
      .phase(a_phase)
   );

   cardinal_router_mesh_xy_nvc #(.DATA_W(64), .NUM_VC(3), .FIFO_DEPTH(3)) u_dut_b (
      .clk(clk), .reset(rst),
      .n_si(si_w[1][0]), .n_di(di_w[1][0]), .n_ri(ri_w[1][0]), .n_so(so_w[1][0]), .n_do(do_w[1][0]), .n_ro(ro_w[1][0]),
      .s_si(si_w[1][1]), .s_di(di_w[1][1]), .s_ri(ri_w[1][1]), .s_so(so_w[1][1]), .s_do(do_w[1][1]), .s_ro(ro_w[1][1]),
      .e_si(si_w[1][2]), .e_di(di_w[1][2]), .e_ri(ri_w[1][2]), .e_so(so_w[1][2]), .e_do(do_w[1][2]), .e_ro(ro_w[1][2]),
      .w_si(si_w[1][3]), .w_di(di_w[1][3]), .w_ri(ri_w[1][3]), .w_so(so_w[1][3]), .w_do(do_w[1][3]), .w_ro(ro_w[1][3]),
      .pe_si(si_w[1][4]), .pe_di(di_w[1][4]), .pe_ri(ri_w[1][4]), .pe_so(so_w[1][4]), .pe_do(do_w[1][4]), .pe_ro(ro_w[1][4]),
      .phase(b_phase)
   );

   // Flit: [63:58] filler, [57] ydir, [56] xdir, [55:52] hx, [51:48] hy, [47:0] tag pattern.
   function automatic logic [63:0] mk(logic yd, logic xd, logic [3:0] hx, logic [3:0] hy, logic [15:0] tag);
      return {6'h2B, yd, xd, hx, hy, ~tag, tag, tag};
   endfunction

   function automatic int cur_ph(int d);
      return (d == 0) ? int'(a_phase) : int'(b_phase);
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic upd_bro();
      ro_w[1][P_E] = !(b_hold && (b_phase == 2'd0));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 5; p++) si_w[d][p] = 1'b0;
      upd_bro();
   endtask

   task automatic wait_phase(int d, int ph);
      for (int i = 0; i < 6 && cur_ph(d) != ph; i++) tick();
      chk($sformatf("wait_phase d%0d", d), 64'(cur_ph(d)), 64'(ph));
   endtask

   task automatic inject(int d, int p, logic [63:0] dat);
      si_w[d][p] = 1'b1;
      di_w[d][p] = dat;
   endtask

   task automatic expect_out(int d, int p, logic [63:0] dat, int vc, int lat);
      exp_t e;
      e.dat = dat;
      e.vc  = vc;
      e.cyc = (lat < 0) ? -1 : cyc + lat;
      exq[d*5+p].push_back(e);
   endtask

   task automatic check_reset(int d);
      chk($sformatf("rst_phase d%0d", d), 64'(cur_ph(d)), 64'd0);
      for (int p = 0; p < 5; p++) begin
         chk($sformatf("rst_so d%0d p%0d", d, p), 64'(so_w[d][p]), 64'd0);
         chk($sformatf("rst_do d%0d p%0d", d, p), do_w[d][p], 64'd0);
         chk($sformatf("rst_ri d%0d p%0d", d, p), 64'(ri_w[d][p]), 64'd1);
      end
   endtask

   exp_t m_e;
   int   m_k;
   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 5; p++) begin
               if (so_w[d][p] && ro_w[d][p]) begin
                  m_k = d*5 + p;
                  n_cmp++;
                  if (exq[m_k].size() == 0) begin
                     n_bad++;
                     $display("FAIL mon_unexpected d%0d p%0d: got %h on vc %0d at cyc %0d, required no flit",
                              d, p, do_w[d][p], cur_ph(d), cyc);
                  end else begin
                     m_e = exq[m_k].pop_front();
                     if (do_w[d][p] !== m_e.dat || cur_ph(d) != m_e.vc || (m_e.cyc >= 0 && cyc != m_e.cyc)) begin
                        n_bad++;
                        $display("FAIL mon_flit d%0d p%0d: got %h vc %0d cyc %0d, required %h vc %0d cyc %0d",
                                 d, p, do_w[d][p], cur_ph(d), cyc, m_e.dat, m_e.vc, m_e.cyc);
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish before 100000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic exp_ri [4];
      int   a_ph_exp [4];
      int   b_ph_exp [4];
      exp_ri   = '{1'b1, 1'b1, 1'b1, 1'b0};
      a_ph_exp = '{0, 1, 0, 1};
      b_ph_exp = '{0, 1, 2, 0};
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 5; p++) begin
            si_w[d][p] = 1'b0;
            di_w[d][p] = '0;
            ro_w[d][p] = 1'b1;
         end
      rst = 1'b1;
      #3;
      check_reset(0);
      check_reset(1);
      tick();
      tick();
      rst = 1'b0;

      // Three-way contention for E on VC0, then prove rr[E] landed on PE.
      wait_phase(0, 0);
      inject(0, P_N, mk(0, 1, 1, 0, 16'h0011));
      inject(0, P_S, mk(0, 1, 1, 0, 16'h0012));
      inject(0, P_W, mk(0, 1, 1, 0, 16'h0013));
      expect_out(0, P_E, mk(0, 1, 0, 0, 16'h0011), 0, 2);
      expect_out(0, P_E, mk(0, 1, 0, 0, 16'h0012), 0, 4);
      expect_out(0, P_E, mk(0, 1, 0, 0, 16'h0013), 0, 6);
      tick();
      repeat (7) tick();
      wait_phase(0, 0);
      inject(0, P_PE, mk(0, 1, 1, 0, 16'h0014));
      inject(0, P_N,  mk(0, 1, 1, 0, 16'h0015));
      expect_out(0, P_E, mk(0, 1, 0, 0, 16'h0014), 0, 2);
      expect_out(0, P_E, mk(0, 1, 0, 0, 16'h0015), 0, 4);
      tick();
      repeat (6) tick();

      // XY route from PE: X first, Y field untouched.
      wait_phase(0, 0);
      inject(0, P_PE, mk(1, 1, 4'd2, 4'd1, 16'h0021));
      expect_out(0, P_E, mk(1, 1, 4'd1, 4'd1, 16'h0021), 0, 2);
      tick();

      // Ejection to PE on both VCs, bit-identical.
      wait_phase(0, 0);
      inject(0, P_N, mk(0, 0, 0, 0, 16'h0031));
      expect_out(0, P_PE, mk(0, 0, 0, 0, 16'h0031), 0, 2);
      tick();
      inject(0, P_N, mk(1, 1, 0, 0, 16'h0032));
      expect_out(0, P_PE, mk(1, 1, 0, 0, 16'h0032), 1, 2);
      tick();

      // West, north, south routes on VC0 and a U-turn back out of E on VC1.
      wait_phase(0, 0);
      inject(0, P_S, mk(0, 0, 4'd3, 4'd0, 16'h0041));
      inject(0, P_E, mk(1, 0, 4'd0, 4'd2, 16'h0042));
      inject(0, P_W, mk(0, 0, 4'd0, 4'd1, 16'h0043));
      expect_out(0, P_W, mk(0, 0, 4'd2, 4'd0, 16'h0041), 0, 2);
      expect_out(0, P_N, mk(1, 0, 4'd0, 4'd1, 16'h0042), 0, 2);
      expect_out(0, P_S, mk(0, 0, 4'd0, 4'd0, 16'h0043), 0, 2);
      tick();
      inject(0, P_E, mk(0, 1, 4'd1, 4'd5, 16'h0045));
      expect_out(0, P_E, mk(0, 1, 4'd0, 4'd5, 16'h0045), 1, 2);
      tick();
      repeat (4) tick();

      // E blocked: one flit parks in outreg, two fill FIFO[W][0], the fourth is refused.
      ro_w[0][P_E] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_phase(0, 0);
         chk($sformatf("bp_w_ri slot%0d", k), 64'(ri_w[0][P_W]), 64'(exp_ri[k]));
         if (k == 3) begin
            chk("bp_e_so_held", 64'(so_w[0][P_E]), 64'd1);
            chk("bp_e_do_held", do_w[0][P_E], mk(0, 1, 0, 0, 16'h0050));
         end
         inject(0, P_W, mk(0, 1, 1, 0, 16'(16'h0050 + k)));
         if (k < 3) expect_out(0, P_E, mk(0, 1, 0, 0, 16'(16'h0050 + k)), 0, -1);
         tick();
         if (k == 0) chk("bp_w_ri_vc1", 64'(ri_w[0][P_W]), 64'd1);
      end
      repeat (3) tick();
      ro_w[0][P_E] = 1'b1;
      repeat (12) tick();

      // Mid-traffic asynchronous reset drops the flit being presented.
      wait_phase(0, 0);
      inject(0, P_N, mk(0, 0, 0, 0, 16'h0071));
      tick();
      tick();
      chk("mid_pe_so_before_reset", 64'(so_w[0][P_PE]), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      check_reset(0);
      check_reset(1);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("phase_a step%0d", i), 64'(cur_ph(0)), 64'(a_ph_exp[i]));
         chk($sformatf("phase_b step%0d", i), 64'(cur_ph(1)), 64'(b_ph_exp[i]));
         tick();
      end
      repeat (4) tick();

      // Instance B: three-cycle minimum latency.
      wait_phase(1, 0);
      inject(1, P_N, mk(0, 0, 0, 0, 16'h0061));
      expect_out(1, P_PE, mk(0, 0, 0, 0, 16'h0061), 0, 3);
      tick();
      repeat (4) tick();

      // Instance B: E refuses VC0 only; VC1 and VC2 flits still get through on time.
      b_hold = 1'b1;
      upd_bro();
      wait_phase(1, 0);
      inject(1, P_W, mk(0, 1, 1, 0, 16'h0062));
      tick();
      inject(1, P_N, mk(0, 1, 2, 0, 16'h0063));
      expect_out(1, P_E, mk(0, 1, 1, 0, 16'h0063), 1, 3);
      tick();
      inject(1, P_S, mk(0, 1, 1, 0, 16'h0064));
      expect_out(1, P_E, mk(0, 1, 0, 0, 16'h0064), 2, 3);
      expect_out(1, P_E, mk(0, 1, 0, 0, 16'h0062), 0, -1);
      tick();
      repeat (4) tick();
      wait_phase(1, 0);
      chk("vc0_held_so", 64'(so_w[1][P_E]), 64'd1);
      chk("vc0_held_do", do_w[1][P_E], mk(0, 1, 0, 0, 16'h0062));
      b_hold = 1'b0;
      upd_bro();
      repeat (8) tick();

      for (int k = 0; k < 10; k++) begin
         n_cmp++;
         if (exq[k].size() != 0) begin
            n_bad++;
            $display("FAIL leftover d%0d p%0d: %0d flits still expected, required 0", k / 5, k % 5, exq[k].size());
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
